// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]  index,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // The read samples the word as it stood before any write on the same edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with programmable wait states in front of dmem_array.
// Optional macro DMEM_MISALIGN_ERR_EN turns addr[1:0] != 0 into an access fault.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [32:0] SPAN      = 33'(4 * DEPTH_WORDS);

  state_t            state;
  req_t              hold;
  logic [3:0]        cnt;
  logic              load_ok;
  logic [WORD_W-1:0] offset;
  logic              in_range;
  logic              misaligned;
  logic              access_ok;
  logic              commit;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_index;
  logic [WORD_W-1:0] arr_rdata;

  // Offset is compared as an unsigned span so addresses near 2^32 never wrap into range.
  assign offset   = hold.addr - BASE_ADDR;
  assign in_range = (hold.addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);

`ifdef DMEM_MISALIGN_ERR_EN
  assign misaligned = |hold.addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign access_ok = in_range && !misaligned;
  assign commit    = (state == WAIT) && (cnt == 4'd0);
  assign arr_we    = commit && hold.write && access_ok;
  assign arr_index = access_ok ? IDX_W'(offset >> 2) : '0;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .wstrb (hold.wstrb),
    .index (arr_index),
    .wdata (hold.wdata),
    .rdata (arr_rdata)
  );

  // The array's read register only matters for a good load; otherwise the response data is zero.
  assign rsp_rdata = load_ok ? arr_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      load_ok   <= 1'b0;
      cnt       <= '0;
      hold      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            hold      <= '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
            cnt       <= WAIT_INIT;
            req_ready <= 1'b0;
            state     <= WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= !access_ok;
            load_ok   <= access_ok && !hold.write;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            load_ok   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the core's load/store port, replacing the zero-latency combinational data memory.
- Accepts one word request at a time over a valid/ready request channel and holds it for a programmable number of wait states.
- Commits byte-masked writes or samples read data, then returns a response over a valid/ready response channel.
- Sits between the core's load/store unit and the word-addressed data array, inside top.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the array.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be 4-byte aligned.
- WAIT_CYCLES, 1: extra cycles inserted between request acceptance and commit. Range 0..15.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept a request.
- req_write, input, 1: 1 = store, 0 = load.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data.
- req_wstrb, input, 4: byte-lane write enables. Bit i controls bits [8i+7:8i]. Ignored on loads.
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: requester accepts the response.
- rsp_rdata, output, 32: load data. 0 for stores and for errors.
- rsp_err, output, 1: access fault (out of range, or misaligned when the optional feature is enabled).

Behaviour:
- Reset:
  - The clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, named reset.
  - While reset is high: FSM in IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1, capture write, addr, wdata, wstrb into holding registers.
  - Load the counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter != 0, decrement it and stay in WAIT.
  - If counter == 0, the next edge commits the access and moves to RESP.
- Commit (on the edge leaving WAIT):
  - Word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored unless the optional feature is enabled.
  - In range means BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS. Compare unsigned, 32-bit; no wrap-around.
  - Out of range: no array write; rsp_err=1, rsp_rdata=0.
  - Store: write only the enabled lanes; rsp_rdata=0. wstrb=0 is a legal no-op with rsp_err=0.
  - Load: rsp_rdata = array word as it stands before this edge's write (no write can coincide, since there is one outstanding access).
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are registered and held stable until handshake.
  - On an edge with rsp_ready=1, clear rsp_valid, rsp_rdata and rsp_err to 0 and go to IDLE.
  - With rsp_ready=0, stay in RESP indefinitely.
- Latency: request accepted at edge E0; rsp_valid is first high after edge E0+WAIT_CYCLES+1.
  - Minimum period between back-to-back accepts is WAIT_CYCLES+3 cycles when rsp_ready is held at 1.
- Requester rules:
  - req_valid may be dropped or changed while req_ready=0 without effect.
  - The responder never drops rsp_valid before the handshake.
- Reset mid-operation:
  - In WAIT: the pending store is discarded and the array is unchanged.
  - In RESP: the response is lost and the array keeps the already-committed write.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: at commit, a request with addr[1:0] != 2'b00 gives rsp_err=1, rsp_rdata=0 and no array write, even if in range.
- Undefined: addr[1:0] is ignored and the access goes to the containing word.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - WORD_W=32, STRB_W=4;
  - the request struct type {write, addr, wdata, wstrb} used by the holding register.
- One sub-module, dmem_array:
  - DEPTH_WORDS x 32 storage;
  - per-byte write enable;
  - synchronous read into the response register;
  - inputs: clk, we, wstrb, index, wdata; output: rdata.

Test Plan:
- Reset then store: WAIT_CYCLES=1; store addr=0x8, wdata=0xDEADBEEF, wstrb=4'hF, rsp_ready=1.
  -> req_ready low for 3 cycles; rsp_valid high exactly after E0+2; rsp_err=0; rsp_rdata=0.
- Read-back: load 0x8 -> rsp_rdata=0xDEADBEEF.
- Partial write: store 0x8, wdata=0x000000AA, wstrb=4'b0001, then load 0x8 -> 0xDEADBEAA.
- Out of range: load 0x100 with DEPTH_WORDS=64 -> rsp_err=1, rsp_rdata=0.
  - Then store 0xFFFFFFFC -> rsp_err=1, and word 63 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0.
  - Then rsp_ready=1 -> IDLE next cycle, and a new request is accepted.
- Reset in WAIT: WAIT_CYCLES=4; store 0x4, 0x12345678; assert reset at cycle 2 of WAIT.
  -> all outputs 0 immediately (async); a later load 0x4 returns the prior value.
  - With DMEM_MISALIGN_ERR_EN defined: load 0x6 -> rsp_err=1.
